// File: rtl/display_datapath_pkg.sv
// Shared constants, mode encoding and FSM state encoding for the display datapath.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package display_datapath_pkg;

    localparam int DEF_SCREEN_W = 160;
    localparam int DEF_SCREEN_H = 120;

    localparam logic [2:0] DEF_BG_COLOUR   = 3'b000;
    localparam logic [2:0] DEF_WIN_COLOUR  = 3'b010;
    localparam logic [2:0] DEF_LOSE_COLOUR = 3'b100;

    typedef enum logic [2:0] {
        MODE_NONE  = 3'd0,
        MODE_GAME  = 3'd1,
        MODE_ERASE = 3'd2,
        MODE_WIN   = 3'd3,
        MODE_LOSE  = 3'd4
    } mode_e;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    // Fixed priority: lose beats win beats erase beats game.
    function automatic mode_e select_mode(input logic lose, input logic win,
                                          input logic erase, input logic game);
        if (lose)  return MODE_LOSE;
        if (win)   return MODE_WIN;
        if (erase) return MODE_ERASE;
        if (game)  return MODE_GAME;
        return MODE_NONE;
    endfunction

endpackage

// File: rtl/display_datapath_if.sv
// Control-FSM to datapath bundle: one-hot enables, block description, pixel stream.
// Latency: n/a (wiring only).
// Backpressure: none; the pixel stream is a free-running strobe.
interface display_datapath_if;
    logic       update;
    logic       draw_game;
    logic       erase;
    logic       draw_win;
    logic       draw_lose;
    logic       enable_plot;
    logic [7:0] block_x;
    logic [6:0] block_y;
    logic [7:0] block_w;
    logic [6:0] block_h;
    logic [2:0] block_colour;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       scan_done;

    modport master (
        output update, draw_game, erase, draw_win, draw_lose, enable_plot,
        output block_x, block_y, block_w, block_h, block_colour,
        input  x, y, colour, plot, scan_done
    );

    modport slave (
        input  update, draw_game, erase, draw_win, draw_lose, enable_plot,
        input  block_x, block_y, block_w, block_h, block_colour,
        output x, y, colour, plot, scan_done
    );
endinterface

// File: rtl/display_datapath_scanner.sv
// 2-D column/row raster counter; extent captured on start, col wraps at width-1.
// Latency: counters move on the edge after start/step; last/empty are combinational.
// Backpressure: none; steps every cycle step_i is high.
module pixel_scanner (
    input  logic       clock,
    input  logic       reset,
    input  logic       start_i,
    input  logic       step_i,
    input  logic [7:0] w_i,
    input  logic [6:0] h_i,
    output logic [7:0] col_o,
    output logic [6:0] row_o,
    output logic       last_o,
    output logic       empty_o
);
    logic [7:0] w_q, w_d, col_q, col_d;
    logic [6:0] h_q, h_d, row_q, row_d;

    // Next counter values: start reloads, step advances x-major.
    always_comb begin
        w_d   = w_q;
        h_d   = h_q;
        col_d = col_q;
        row_d = row_q;
        if (start_i) begin
            w_d   = w_i;
            h_d   = h_i;
            col_d = 8'd0;
            row_d = 7'd0;
        end else if (step_i) begin
            if (col_q == w_q - 8'd1) begin
                col_d = 8'd0;
                row_d = row_q + 7'd1;
            end else begin
                col_d = col_q + 8'd1;
            end
        end
    end

    // Counter and extent registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            w_q   <= 8'd0;
            h_q   <= 7'd0;
            col_q <= 8'd0;
            row_q <= 7'd0;
        end else begin
            w_q   <= w_d;
            h_q   <= h_d;
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    assign empty_o = (w_q == 8'd0) || (h_q == 7'd0);
    assign last_o  = empty_o || ((col_q == w_q - 8'd1) && (row_q == h_q - 7'd1));
    assign col_o   = col_q;
    assign row_o   = row_q;
endmodule

// File: rtl/display_datapath.sv
// Pixel datapath: latches a block on update, then raster-scans it or fills the screen.
// Latency: pixel (c,r) appears on x/y/colour/plot one cycle after its scan cycle.
// Backpressure: none; one pixel per clock, enable_plot only masks the strobe.
module display_datapath
    import display_datapath_pkg::*;
#(
    parameter int         SCREEN_W    = DEF_SCREEN_W,
    parameter int         SCREEN_H    = DEF_SCREEN_H,
    parameter logic [2:0] BG_COLOUR   = DEF_BG_COLOUR,
    parameter logic [2:0] WIN_COLOUR  = DEF_WIN_COLOUR,
    parameter logic [2:0] LOSE_COLOUR = DEF_LOSE_COLOUR
) (
    input logic               clock,
    input logic               reset,
    display_datapath_if.slave bus
);
    mode_e      mode_now, mode_q;
    logic [1:0] state_q, state_d;
    logic [7:0] sx_q, sw_q, org_x_q, x_q;
    logic [6:0] sy_q, sh_q, org_y_q, y_q;
    logic [2:0] scol_q, pix_colour_q, colour_q;
    logic       plot_q, done_q;

    logic       load, in_scan, same_mode, block_mode, pix_vld, on_screen, last, empty;
    logic [7:0] col, ext_w;
    logic [6:0] row, ext_h;
    logic [8:0] x_sum;
    logic [7:0] y_sum;

    assign mode_now   = select_mode(bus.draw_lose, bus.draw_win, bus.erase, bus.draw_game);
    assign in_scan    = (state_q == S_SCAN);
    assign same_mode  = (mode_now == mode_q);
    // A new scan starts from idle, or whenever the requested mode differs (abort/restart).
    assign load       = (mode_now != MODE_NONE) && ((state_q == S_IDLE) || !same_mode);
    assign block_mode = (mode_now == MODE_GAME) || (mode_now == MODE_ERASE);
    assign ext_w      = block_mode ? sw_q : 8'(SCREEN_W);
    assign ext_h      = block_mode ? sh_q : 7'(SCREEN_H);
    assign pix_vld    = in_scan && same_mode && !empty;
    assign x_sum      = {1'b0, org_x_q} + {1'b0, col};
    assign y_sum      = {1'b0, org_y_q} + {1'b0, row};
    assign on_screen  = (x_sum < 9'(SCREEN_W)) && (y_sum < 8'(SCREEN_H));

    pixel_scanner u_scanner (
        .clock   (clock),
        .reset   (reset),
        .start_i (load),
        .step_i  (in_scan),
        .w_i     (ext_w),
        .h_i     (ext_h),
        .col_o   (col),
        .row_o   (row),
        .last_o  (last),
        .empty_o (empty)
    );

    // FSM next state: load wins, dropped mode returns to idle, last pixel parks in hold.
    always_comb begin
        state_d = state_q;
        if (load)                          state_d = S_SCAN;
        else if (mode_now == MODE_NONE)    state_d = S_IDLE;
        else if (in_scan && last)          state_d = S_HOLD;
    end

    // Shadow block registers, written only while no draw mode is requested.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sx_q   <= 8'd0;
            sy_q   <= 7'd0;
            sw_q   <= 8'd0;
            sh_q   <= 7'd0;
            scol_q <= 3'd0;
        end else if (bus.update && (mode_now == MODE_NONE)) begin
            sx_q   <= bus.block_x;
            sy_q   <= bus.block_y;
            sw_q   <= bus.block_w;
            sh_q   <= bus.block_h;
            scol_q <= bus.block_colour;
        end
    end

    // FSM state plus per-scan origin/colour captured at scan start.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            mode_q       <= MODE_NONE;
            org_x_q      <= 8'd0;
            org_y_q      <= 7'd0;
            pix_colour_q <= 3'd0;
        end else begin
            state_q <= state_d;
            // Outside a load the request either matches mode_q or is NONE, so tracking it is exact.
            mode_q  <= mode_now;
            if (load) begin
                org_x_q <= block_mode ? sx_q : 8'd0;
                org_y_q <= block_mode ? sy_q : 7'd0;
                case (mode_now)
                    MODE_GAME:  pix_colour_q <= scol_q;
                    MODE_ERASE: pix_colour_q <= BG_COLOUR;
                    MODE_WIN:   pix_colour_q <= WIN_COLOUR;
                    default:    pix_colour_q <= LOSE_COLOUR;
                endcase
            end
        end
    end

    // Registered pixel outputs; coordinates hold between valid pixels.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            x_q      <= 8'd0;
            y_q      <= 7'd0;
            colour_q <= 3'd0;
            plot_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            if (pix_vld) begin
                x_q      <= x_sum[7:0];
                y_q      <= y_sum[6:0];
                colour_q <= pix_colour_q;
            end
            plot_q <= bus.enable_plot && pix_vld && on_screen;
            done_q <= in_scan && same_mode && last;
        end
    end

    assign bus.x         = x_q;
    assign bus.y         = y_q;
    assign bus.colour    = colour_q;
    assign bus.plot      = plot_q;
    assign bus.scan_done = done_q;
endmodule

// File: tb/tb_display_datapath.sv
// Self-checking bench for display_datapath: vector table, random blocks, full-screen and reset cases.
// Latency: n/a.
// Backpressure: n/a.
module tb_display_datapath;
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    display_datapath_if bus ();
    display_datapath dut (.clock(clock), .reset(reset), .bus(bus));

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

    typedef struct {
        int bx, by, bw, bh, col, mode;
        bit en;
        int exp_len, exp_n, fx, fy, lx, ly, ec;
    } vec_t;

    pix_t got_q[$];
    pix_t exp_q[$];
    int   done_cnt;
    int   checks = 0;
    int   errors = 0;

    // Pixel/done monitor sampled mid-cycle.
    always @(negedge clock) begin
        if (!reset) begin
            if (bus.plot) got_q.push_back(pix_t'{bus.x, bus.y, bus.colour});
            if (bus.scan_done) done_cnt++;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_pix(input string name, input pix_t a, input int ex, input int ey, input int ec);
        checks++;
        if (a.x != 8'(ex) || a.y != 7'(ey) || a.c != 3'(ec)) begin
            errors++;
            $display("FAIL %s: got (%0d,%0d) colour %0d expected (%0d,%0d) colour %0d",
                     name, a.x, a.y, a.c, ex, ey, ec);
        end
    endtask

    // Reference: every on-screen pixel of the rectangle, row-major.
    task automatic expect_block(input int bx, input int by, input int bw, input int bh,
                                input int col, input bit en);
        exp_q.delete();
        if (!en) return;
        for (int r = 0; r < bh; r++)
            for (int c = 0; c < bw; c++)
                if (bx + c < 160 && by + r < 120)
                    exp_q.push_back(pix_t'{8'(bx + c), 7'(by + r), 3'(col)});
    endtask

    task automatic compare_pix(input string name);
        int mism = 0;
        chk({name, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            if (got_q[i] != exp_q[i]) begin
                if (mism == 0)
                    $display("FAIL %s_first_bad idx %0d: got (%0d,%0d,%0d) expected (%0d,%0d,%0d)",
                             name, i, got_q[i].x, got_q[i].y, got_q[i].c,
                             exp_q[i].x, exp_q[i].y, exp_q[i].c);
                mism++;
            end
        end
        chk({name, "_pixels_bad"}, mism, 0);
    endtask

    task automatic set_mode(input int m);
        bus.draw_game = (m == 1);
        bus.erase     = (m == 2);
        bus.draw_win  = (m == 3);
        bus.draw_lose = (m == 4);
    endtask

    task automatic do_update(input int bx, input int by, input int bw, input int bh, input int col);
        @(negedge clock);
        bus.block_x = 8'(bx); bus.block_y = 7'(by);
        bus.block_w = 8'(bw); bus.block_h = 7'(bh);
        bus.block_colour = 3'(col);
        bus.update = 1'b1;
        @(negedge clock);
        bus.update = 1'b0;
    endtask

    // Request a mode, measure cycles until scan_done, hold a few cycles, release.
    task automatic run_scan(input int m, input bit en, input int exp_len, input bit upd_hold,
                            input string name);
        int  n = 0;
        bit  seen = 0;
        @(negedge clock);
        got_q.delete();
        done_cnt = 0;
        bus.enable_plot = en;
        set_mode(m);
        if (upd_hold) begin
            bus.block_x = 8'd100; bus.block_y = 7'd100;
            bus.block_w = 8'd5;   bus.block_h = 7'd5;
            bus.block_colour = 3'd1;
            bus.update = 1'b1;
        end
        while (n < 25000 && !seen) begin
            @(negedge clock);
            n++;
            if (bus.scan_done) seen = 1;
        end
        chk({name, "_len"}, seen ? n - 1 : -1, exp_len);
        repeat (3) @(negedge clock);
        set_mode(0);
        bus.update = 1'b0;
        repeat (2) @(negedge clock);
        chk({name, "_done_pulses"}, done_cnt, 1);
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{10, 20, 4, 3, 5, 1, 1, 12, 12, 10, 20, 13, 22, 5};
        vecs[1] = '{10, 20, 4, 3, 5, 2, 1, 12, 12, 10, 20, 13, 22, 0};
        vecs[2] = '{158, 0, 4, 1, 3, 1, 1, 4, 2, 158, 0, 159, 0, 3};
        vecs[3] = '{5, 5, 0, 3, 6, 1, 1, 1, 0, 0, 0, 0, 0, 0};
        vecs[4] = '{10, 20, 4, 3, 5, 1, 0, 12, 0, 0, 0, 0, 0, 0};
        vecs[5] = '{0, 118, 2, 5, 7, 1, 1, 10, 4, 0, 118, 1, 119, 7};
        vecs[6] = '{7, 9, 1, 1, 1, 2, 1, 1, 1, 7, 9, 7, 9, 0};

        reset = 1'b1;
        bus.update = 0; bus.enable_plot = 1;
        set_mode(0);
        bus.block_x = 0; bus.block_y = 0; bus.block_w = 0; bus.block_h = 0; bus.block_colour = 0;
        repeat (2) @(negedge clock);
        chk("rst_x", bus.x, 0);
        chk("rst_y", bus.y, 0);
        chk("rst_colour", bus.colour, 0);
        chk("rst_plot", bus.plot, 0);
        chk("rst_done", bus.scan_done, 0);
        reset = 1'b0;
        @(negedge clock);

        // Table-driven block scans.
        for (int i = 0; i < 7; i++) begin
            string nm = $sformatf("vec%0d", i);
            do_update(vecs[i].bx, vecs[i].by, vecs[i].bw, vecs[i].bh, vecs[i].col);
            run_scan(vecs[i].mode, vecs[i].en, vecs[i].exp_len, 0, nm);
            chk({nm, "_n"}, got_q.size(), vecs[i].exp_n);
            if (vecs[i].exp_n > 0 && got_q.size() > 0) begin
                chk_pix({nm, "_first"}, got_q[0], vecs[i].fx, vecs[i].fy, vecs[i].ec);
                chk_pix({nm, "_last"}, got_q[$], vecs[i].lx, vecs[i].ly, vecs[i].ec);
            end
            expect_block(vecs[i].bx, vecs[i].by, vecs[i].bw, vecs[i].bh, vecs[i].ec, vecs[i].en);
            compare_pix(nm);
        end

        // Random blocks against the reference model.
        for (int i = 0; i < 25; i++) begin
            int bx = $urandom_range(0, 170);
            int by = $urandom_range(0, 125);
            int bw = $urandom_range(0, 6);
            int bh = $urandom_range(0, 5);
            int bc = $urandom_range(0, 7);
            int md = $urandom_range(1, 2);
            bit en = ($urandom_range(0, 3) != 0);
            string nm = $sformatf("rnd%0d", i);
            do_update(bx, by, bw, bh, bc);
            run_scan(md, en, (bw == 0 || bh == 0) ? 1 : bw * bh, 0, nm);
            expect_block(bx, by, bw, bh, (md == 2) ? 0 : bc, en);
            compare_pix(nm);
        end

        // Update requested while drawing must not disturb the latched block.
        do_update(30, 40, 2, 2, 3);
        run_scan(1, 1, 4, 1, "upd_ignored");
        expect_block(30, 40, 2, 2, 3, 1);
        compare_pix("upd_ignored");
        run_scan(1, 1, 4, 0, "upd_ignored_again");
        compare_pix("upd_ignored_again");

        // Full-screen win fill.
        run_scan(3, 1, 19200, 0, "win");
        expect_block(0, 0, 160, 120, 2, 1);
        compare_pix("win");

        // Win aborted by lose after 300 cycles: 299 win pixels, then a full lose scan.
        begin
            int  n = 0;
            bit  seen = 0;
            int  bad = 0;
            @(negedge clock);
            got_q.delete();
            done_cnt = 0;
            set_mode(3);
            repeat (300) @(negedge clock);
            chk("abort_no_done_yet", done_cnt, 0);
            bus.draw_lose = 1'b1;
            while (n < 25000 && !seen) begin
                @(negedge clock);
                n++;
                if (bus.scan_done) seen = 1;
            end
            chk("abort_lose_len", seen ? n - 1 : -1, 19200);
            set_mode(0);
            repeat (2) @(negedge clock);
            chk("abort_done_pulses", done_cnt, 1);
            chk("abort_count", got_q.size(), 299 + 19200);
            if (got_q.size() == 299 + 19200) begin
                for (int i = 0; i < 299; i++)
                    if (got_q[i] != pix_t'{8'(i % 160), 7'(i / 160), 3'd2}) bad++;
                for (int j = 0; j < 19200; j++)
                    if (got_q[299 + j] != pix_t'{8'(j % 160), 7'(j / 160), 3'd4}) bad++;
            end
            chk("abort_pixels_bad", bad, 0);
        end

        // Asynchronous reset in the middle of a scan.
        do_update(20, 30, 8, 8, 6);
        @(negedge clock);
        bus.enable_plot = 1'b1;
        set_mode(1);
        repeat (10) @(negedge clock);
        reset = 1'b1;
        #1;
        chk("midrst_x", bus.x, 0);
        chk("midrst_y", bus.y, 0);
        chk("midrst_colour", bus.colour, 0);
        chk("midrst_plot", bus.plot, 0);
        @(negedge clock);
        set_mode(0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        // Shadow registers were cleared, so the next draw is an empty block.
        run_scan(1, 1, 1, 0, "post_rst");
        chk("post_rst_plots", got_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
